bus_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state data bus among NREQ requesters. Each requester's tri-state driver is enabled by one bit of grant. The block guarantees one-hot or all-zero grant and inserts a programmable dead (turnaround) gap between owners so drivers never overlap. It is the N-way successor to the two-device bus controller and sits between the requesting devices and their tristate_buf output enables.

---
 rtl/bus_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner selection for a shared tri-state bus. Grant is one-hot or zero, and a programmable all-zero turnaround gap separates owners.
// Optional forced release of a long-holding owner is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned MAX_HOLD    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    bus_busy,
   output logic                    timeout
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned TCW = 3;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam int unsigned HCW = 8;
`endif

   // Elaboration-time parameter range guards
   if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("bus_rr_arbiter: NREQ must be 2..16");
   end
   if (TURN_CYCLES < 1 || TURN_CYCLES > 7) begin : g_bad_turn
      $error("bus_rr_arbiter: TURN_CYCLES must be 1..7");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("bus_rr_arbiter: MAX_HOLD must be 2..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    ptr_nxt;
   logic [TCW-1:0]    turn_cnt;
   logic [TCW-1:0]    turn_nxt;
   logic [NREQ-1:0]   grant_nxt;
   logic [IDW-1:0]    grant_id_nxt;
   logic              bus_busy_nxt;
   logic              timeout_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
   logic [HCW-1:0]    hold;
   logic [HCW-1:0]    hold_nxt;
`endif

   logic              win_valid;
   logic [IDW-1:0]    win_id;
   logic [IDW-1:0]    cand;
   logic              drop_rel;
   logic              force_rel;
   logic              arb_now;

   // Rotating-priority pick: first set req bit after the last owner, with wrap
   always_comb begin : p_pick
      win_valid = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = IDW'((32'(ptr) + i) % NREQ);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Release conditions for the current owner
   always_comb begin : p_release
      drop_rel  = !req[grant_id];
      force_rel = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      force_rel = (hold == HCW'(MAX_HOLD)) && (|(req & ~grant));
`endif
      arb_now   = (state == ST_IDLE) || ((state == ST_TURN) && (turn_cnt == '0));
   end

   // State register plus registered outputs
   always_ff @(posedge clk) begin : p_state
      if (!rst) begin
         state    <= ST_IDLE;
         grant    <= '0;
         grant_id <= '0;
         bus_busy <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= IDW'(NREQ - 1);
         turn_cnt <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         hold     <= '0;
`endif
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         bus_busy <= bus_busy_nxt;
         timeout  <= timeout_nxt;
         ptr      <= ptr_nxt;
         turn_cnt <= turn_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
         hold     <= hold_nxt;
`endif
      end
   end

   // Next-state logic
   always_comb begin : p_next
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (win_valid) state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (drop_rel || force_rel) state_nxt = ST_TURN;
         end
         ST_TURN: begin
            if (turn_cnt == '0) state_nxt = win_valid ? ST_GRANT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin : p_out
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      ptr_nxt      = ptr;
      turn_nxt     = turn_cnt;
      timeout_nxt  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_nxt     = hold;
`endif
      case (state)
         ST_GRANT: begin
            if (drop_rel || force_rel) begin
               grant_nxt   = '0;
               turn_nxt    = TCW'(TURN_CYCLES - 1);
               timeout_nxt = force_rel && !drop_rel;
            end else begin
`ifdef BUS_ARB_TIMEOUT_EN
               if (hold != HCW'(MAX_HOLD)) hold_nxt = hold + HCW'(1);
`endif
            end
         end
         ST_TURN: begin
            if (turn_cnt != '0) turn_nxt = turn_cnt - TCW'(1);
         end
         default: ;
      endcase
      if (arb_now) begin
         grant_nxt = '0;
         if (win_valid) begin
            grant_nxt    = NREQ'(1) << win_id;
            grant_id_nxt = win_id;
            ptr_nxt      = win_id;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_nxt     = HCW'(1);
`endif
         end
      end
      bus_busy_nxt = |grant_nxt;
   end

`ifndef SYNTHESIS
   // Bus-safety invariants
   a_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
   a_no_switch : assert property (@(posedge clk) disable iff (!rst)
      ((grant != '0) && ($past(grant) != '0)) |-> (grant == $past(grant)));
   a_id_match : assert property (@(posedge clk) disable iff (!rst)
      (bus_busy == (|grant)) && (!bus_busy || grant[grant_id]));
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: two instances (turnaround 1 and 3 cycles), MAX_HOLD=4.
// Expectations follow whether BUS_ARB_TIMEOUT_EN is defined for the build.
module tb_bus_rr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
   localparam logic [3:0] RR_G  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   localparam logic [1:0] RR_ID [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] req1 = '0;
   logic [NREQ-1:0] req3 = '0;
   logic [NREQ-1:0] grant1;
   logic [NREQ-1:0] grant3;
   logic [IDW-1:0]  id1;
   logic [IDW-1:0]  id3;
   logic            busy1;
   logic            busy3;
   logic            tmo1;
   logic            tmo3;
   int              n_checks = 0;
   int              n_fail   = 0;

   always #5 clk = ~clk;

   bus_rr_arbiter #(.NREQ(NREQ), .TURN_CYCLES(1), .MAX_HOLD(4)) u_dut1 (
      .clk(clk), .rst(rst), .req(req1), .grant(grant1),
      .grant_id(id1), .bus_busy(busy1), .timeout(tmo1)
   );

   bus_rr_arbiter #(.NREQ(NREQ), .TURN_CYCLES(3), .MAX_HOLD(4)) u_dut3 (
      .clk(clk), .rst(rst), .req(req3), .grant(grant3),
      .grant_id(id3), .bus_busy(busy3), .timeout(tmo3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      req1 = '0;
      req3 = '0;
      step();
      step();
      rst  = 1'b1;
   endtask

   task automatic set_req(input int d, input logic [3:0] v);
      if (d == 0) req1 = v;
      else        req3 = v;
   endtask

   task automatic sample(input int d, output logic [3:0] g, output logic [1:0] id,
                         output logic b, output logic t);
      g  = (d == 0) ? grant1 : grant3;
      id = (d == 0) ? id1    : id3;
      b  = (d == 0) ? busy1  : busy3;
      t  = (d == 0) ? tmo1   : tmo3;
   endtask

   task automatic test_reset();
      rst  = 1'b0;
      req1 = 4'b1111;
      req3 = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({grant1, busy1, tmo1, grant3, busy3, tmo3} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got g1=%b b1=%b t1=%b g3=%b b3=%b t3=%b want all zero",
                     grant1, busy1, tmo1, grant3, busy3, tmo3);
         end
      end
      rst = 1'b1;
      step();
      n_checks++;
      if ({grant1, id1, busy1} !== {4'b0001, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_release: got g=%b id=%0d b=%b want g=0001 id=0 b=1", grant1, id1, busy1);
      end
      n_checks++;
      if ({grant3, id3, busy3} !== {4'b0001, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_release3: got g=%b id=%0d b=%b want g=0001 id=0 b=1", grant3, id3, busy3);
      end
   endtask

   task automatic test_single();
      do_reset();
      req1 = 4'b0100;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_checks++;
         if ({grant1, id1, busy1, tmo1} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_hold[%0d]: got g=%b id=%0d b=%b want g=0100 id=2 b=1", k, grant1, id1, busy1);
         end
      end
      req1 = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         step();
         n_checks++;
         if ({grant1, busy1} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_release[%0d]: got g=%b b=%b want g=0000 b=0", k, grant1, busy1);
         end
      end
   endtask

   task automatic test_round_robin(input int d, input int turn);
      logic [3:0] cur;
      logic [3:0] g;
      logic [1:0] id;
      logic       b;
      logic       t;
      do_reset();
      cur = 4'b1111;
      set_req(d, cur);
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 3; k++) begin
            step();
            sample(d, g, id, b, t);
            n_checks++;
            if ({g, id, b, t} !== {RR_G[n], RR_ID[n], 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL rr_grant t%0d n%0d k%0d: got g=%b id=%0d b=%b t=%b want g=%b id=%0d",
                        turn, n, k, g, id, b, t, RR_G[n], RR_ID[n]);
            end
         end
         cur[RR_ID[n]] = 1'b0;
         set_req(d, cur);
         step();
         sample(d, g, id, b, t);
         n_checks++;
         if ({g, b} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL rr_release t%0d n%0d: got g=%b b=%b want g=0000 b=0", turn, n, g, b);
         end
         cur[RR_ID[n]] = 1'b1;
         set_req(d, cur);
         for (int k = 1; k < turn; k++) begin
            step();
            sample(d, g, id, b, t);
            n_checks++;
            if (g !== 4'b0000) begin
               n_fail++;
               $display("FAIL rr_gap t%0d n%0d k%0d: got g=%b want 0000", turn, n, k, g);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req1 = 4'b0010;
      step();
      step();
      n_checks++;
      if ({grant1, id1} !== {4'b0010, 2'd1}) begin
         n_fail++;
         $display("FAIL simul_owner1: got g=%b id=%0d want g=0010 id=1", grant1, id1);
      end
      req1 = 4'b1001;
      step();
      n_checks++;
      if (grant1 !== 4'b0000) begin
         n_fail++;
         $display("FAIL simul_release: got g=%b want 0000", grant1);
      end
      step();
      n_checks++;
      if ({grant1, id1} !== {4'b1000, 2'd3}) begin
         n_fail++;
         $display("FAIL simul_next3: got g=%b id=%0d want g=1000 id=3", grant1, id1);
      end
      req1 = 4'b0001;
      step();
      step();
      n_checks++;
      if ({grant1, id1} !== {4'b0001, 2'd0}) begin
         n_fail++;
         $display("FAIL simul_wrap0: got g=%b id=%0d want g=0001 id=0", grant1, id1);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req1 = 4'b0001;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_checks++;
         if ({grant1, tmo1} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_own[%0d]: got g=%b t=%b want g=0001 t=0", k, grant1, tmo1);
         end
      end
      req1 = 4'b0011;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int k = 3; k <= 4; k++) begin
         step();
         n_checks++;
         if ({grant1, tmo1} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_own[%0d]: got g=%b t=%b want g=0001 t=0", k, grant1, tmo1);
         end
      end
      step();
      n_checks++;
      if ({grant1, busy1, tmo1} !== {4'b0000, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL tmo_force: got g=%b b=%b t=%b want g=0000 b=0 t=1", grant1, busy1, tmo1);
      end
      step();
      n_checks++;
      if ({grant1, id1, tmo1} !== {4'b0010, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL tmo_next: got g=%b id=%0d t=%b want g=0010 id=1 t=0", grant1, id1, tmo1);
      end
`else
      for (int k = 3; k <= 55; k++) begin
         step();
         n_checks++;
         if ({grant1, tmo1} !== {4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_off_hold[%0d]: got g=%b t=%b want g=0001 t=0", k, grant1, tmo1);
         end
      end
`endif
   endtask

   task automatic test_lone_owner();
      do_reset();
      req1 = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         step();
         n_checks++;
         if ({grant1, busy1, tmo1} !== {4'b0001, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lone_hold[%0d]: got g=%b b=%b t=%b want g=0001 b=1 t=0", k, grant1, busy1, tmo1);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req1 = 4'b0010;
      step();
      step();
      n_checks++;
      if (grant1 !== 4'b0010) begin
         n_fail++;
         $display("FAIL midrst_pre: got g=%b want 0010", grant1);
      end
      rst  = 1'b0;
      req1 = 4'b0011;
      step();
      n_checks++;
      if ({grant1, busy1} !== {4'b0000, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_drop: got g=%b b=%b want g=0000 b=0", grant1, busy1);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if ({grant1, id1} !== {4'b0001, 2'd0}) begin
         n_fail++;
         $display("FAIL midrst_after: got g=%b id=%0d want g=0001 id=0", grant1, id1);
      end
      // Owner 0 holds the pointer; a reset must bring priority back to 0, not 1
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      n_checks++;
      if ({grant1, id1} !== {4'b0001, 2'd0}) begin
         n_fail++;
         $display("FAIL midrst_ptr: got g=%b id=%0d want g=0001 id=0", grant1, id1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin(0, 1);
      test_round_robin(1, 3);
      test_simultaneous();
      test_timeout();
      test_lone_owner();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
